scale_hdown_reader: RTL and testbench
=====================================

// Module: scale_hdown_reader
// PURPOSE
//  Horizontal nearest-neighbour downscaler on the read side of the scaler line FIFO.
//  - Pops RGB565 pixels from the FIFO read port.
//  - Keeps input pixel x only when x == floor(k*step) for output index k.
//  - Streams kept pixels downstream over a valid/ready interface, marking end of line.
//  - Drains every input pixel of each line, so the FIFO stays line-aligned.
// PARAMETERS
//  DATA_WIDTH  16  pixel width; equals FIFO read data width
//  CNT_WIDTH   12  width of pixel counters and line widths
//  FRAC_WIDTH   8  fractional bits of step (fixed point, integer part CNT_WIDTH bits)
// PORTS
//  rd_clk        in   1                     single clock; same as FIFO read clock
//  rd_rst        in   1                     synchronous, active-high reset
//  enable        in   1                     level; run line after line while high
//  src_width     in   CNT_WIDTH             input pixels per line; latched at line start
//  dst_width     in   CNT_WIDTH             maximum output pixels per line; latched at line start
//  step          in   CNT_WIDTH+FRAC_WIDTH  src/dst ratio in fixed point; latched at line start
//  fifo_rd_en    out  1                     FIFO read strobe
//  fifo_rd_data  in   DATA_WIDTH            FIFO data; valid the cycle after fifo_rd_en
//  fifo_empty    in   1                     FIFO empty flag
//  pix_data      out  DATA_WIDTH            output pixel
//  pix_valid     out  1                     output pixel valid
//  pix_ready     in   1                     downstream accept
//  pix_eol       out  1                     qualifies pix_data as last pixel of the line
//  line_done     out  1                     one-cycle pulse when a line is fully consumed and emitted
//  busy          out  1                     high in any state other than IDLE
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; counters and buffer cleared.
//    A FIFO read in flight at reset is discarded.
//  - States
//    IDLE -> RUN: when enable=1. Latch src_width/dst_width/step.
//      Step integer part 0 is forced to 1.0. Set acc=0, src_x=0, out_cnt=0.
//    RUN -> FLUSH: when src_x reaches src_w. src_x counts data beats returned, not rd_en issues.
//    FLUSH -> END: when the output buffer is empty.
//    END: line_done=1 for exactly 1 cycle.
//      Then RUN (relatch config, clear counters) if enable=1, else IDLE.
//  - Reads
//    - Condition: fifo_rd_en = RUN & !fifo_empty & (issued reads < src_w) & (buf_occ + inflight < 2).
//    - buf_occ is evaluated after this cycle's pop.
//    - Read latency is 1 cycle.
//    - Sustained rate is 1 pixel/cycle when FIFO is non-empty and pix_ready=1.
//  - Keep rule for each returned beat at position src_x
//    - Keep when out_cnt < dst_w and src_x == acc[int].
//    - On keep: acc += step; out_cnt++.
//    - Non-kept beats are dropped silently.
//    - step >= 1.0 guarantees at most one keep per input beat.
//    - acc is CNT_WIDTH+FRAC_WIDTH+1 bits and never wraps.
//  - eol on a kept pixel when out_cnt+1 == dst_w, or when int(acc+step) >= src_w.
//    Exactly one eol per line with at least one output.
//  - Output buffer
//    - 2-entry skid buffer in FIFO order. pix_valid = buf_occ != 0.
//    - pix_data and pix_eol hold stable while pix_valid & !pix_ready.
//  - enable falling mid-line: the current line completes, then IDLE.
//    Config input changes mid-line are ignored.
//  - dst_w = 0: the line is fully drained, no pixels are emitted, line_done still pulses.
//  - src_w = 0: RUN -> FLUSH -> END immediately, with no reads.
// TESTING
//  1) src=8, dst=4, step=0x200 (2.0), data=0x0010*x.
//     -> pix 0x0000,0x0020,0x0040,0x0060; eol on 0x0060; 8 reads; 1 line_done.
//  2) src=6, dst=4, step=0x180 (1.5).
//     -> kept x=0,1,3,4; eol on x=4; x=2,5 dropped; FIFO drained to 0.
//  3) src=dst=5, step=0x100, pix_ready=1, FIFO pre-filled.
//     -> 5 pixels on 5 consecutive cycles, passthrough; eol on 5th.
//  4) Case 1 with pix_ready low for 10 cycles mid-line.
//     -> rd_en stalls; buf_occ <= 2; no pixel lost or duplicated; pix_data stable.
//  5) src=4, dst=8, step=0x100.
//     -> 4 outputs, eol on the 4th. Case with dst=0 -> 0 outputs, 4 reads, line_done.
//  6) rd_rst at the 3rd pixel, then enable drops mid-next line.
//     -> outputs 0 at reset; next line completes; then IDLE, busy=0.

Source files
------------

// File: rtl/scale_hdown_reader.sv
// ---------------------------------------------------------------------------
// scale_hdown_reader
//
// Horizontal nearest-neighbour downscaler sitting on the read side of the
// scaler line FIFO. Every input pixel of a line is popped from the FIFO, so
// the FIFO stays line-aligned. The input pixel at position x is kept only
// when x == floor(k*step) for the next output index k. Kept pixels are
// streamed out through a 2-entry skid buffer, and the last pixel of each line
// is flagged with pix_eol.
//
// Ports
//   rd_clk, rd_rst   single clock (the FIFO read clock), sync active-high reset
//   enable           level; keep processing line after line while high
//   src_width        input pixels per line       (latched at line start)
//   dst_width        max output pixels per line  (latched at line start)
//   step             src/dst ratio, CNT_WIDTH.FRAC_WIDTH fixed point (latched)
//   fifo_rd_en       FIFO read strobe; data returns one cycle later
//   fifo_rd_data     FIFO read data
//   fifo_empty       FIFO empty flag
//   pix_data/pix_eol output pixel and its end-of-line flag
//   pix_valid        output valid
//   pix_ready        downstream accept
//   line_done        one-cycle pulse once a line is fully consumed and emitted
//   busy             high whenever the FSM is not IDLE
//   dbg_state        current FSM state (IDLE=0, RUN=1, FLUSH=2, END=3)
//
// Handshake: a pixel transfers on a rising clock edge where pix_valid and
// pix_ready are both high. While pix_valid is high and pix_ready is low,
// pix_data and pix_eol stay stable. pix_valid does not depend on pix_ready.
// ---------------------------------------------------------------------------
module scale_hdown_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 12,
    parameter int FRAC_WIDTH = 8
) (
    input  logic                          rd_clk,
    input  logic                          rd_rst,
    input  logic                          enable,
    input  logic [CNT_WIDTH-1:0]          src_width,
    input  logic [CNT_WIDTH-1:0]          dst_width,
    input  logic [CNT_WIDTH+FRAC_WIDTH-1:0] step,
    output logic                          fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]         fifo_rd_data,
    input  logic                          fifo_empty,
    output logic [DATA_WIDTH-1:0]         pix_data,
    output logic                          pix_valid,
    input  logic                          pix_ready,
    output logic                          pix_eol,
    output logic                          line_done,
    output logic                          busy,
    output logic [1:0]                    dbg_state
);

    localparam int SW = CNT_WIDTH + FRAC_WIDTH;  // step width
    localparam int AW = SW + 1;                  // accumulator width
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_END   = 2'd3
    } state_t;

    state_t                 state_q,    state_d;
    logic [CNT_WIDTH-1:0]   src_w_q,    src_w_d;
    logic [CNT_WIDTH-1:0]   dst_w_q,    dst_w_d;
    logic [SW-1:0]          step_q,     step_d;
    logic [AW-1:0]          acc_q,      acc_d;
    logic [CNT_WIDTH-1:0]   src_x_q,    src_x_d;
    logic [CNT_WIDTH-1:0]   issued_q,   issued_d;
    logic [CNT_WIDTH-1:0]   out_cnt_q,  out_cnt_d;
    logic                   inflight_q, inflight_d;
    logic [DATA_WIDTH-1:0]  buf0_data_q, buf0_data_d;
    logic [DATA_WIDTH-1:0]  buf1_data_q, buf1_data_d;
    logic                   buf0_eol_q,  buf0_eol_d;
    logic                   buf1_eol_q,  buf1_eol_d;
    logic [1:0]             buf_occ_q,   buf_occ_d;

    logic                   pop;
    logic [1:0]             occ_after_pop;
    logic [AW-1:0]          acc_next;
    logic [CNT_WIDTH:0]     acc_int;
    logic [CNT_WIDTH:0]     next_int;
    logic                   keep;
    logic                   keep_eol;

    // Output side of the skid buffer: entry 0 is always the head.
    assign pix_valid = (buf_occ_q != 2'd0);
    assign pix_data  = buf0_data_q;
    assign pix_eol   = buf0_eol_q;
    assign busy      = (state_q != S_IDLE);
    assign dbg_state = state_q;

    assign pop           = pix_valid & pix_ready;
    assign occ_after_pop = buf_occ_q - {1'b0, pop};

    // A read is only issued if the beat it returns next cycle is guaranteed a
    // buffer slot: occupancy after this cycle's pop plus the beat landing now
    // must leave at least one entry free.
    assign fifo_rd_en = (state_q == S_RUN) && !fifo_empty &&
                        (issued_q < src_w_q) &&
                        ((occ_after_pop + {1'b0, inflight_q}) < 2'd2);

    assign acc_next = acc_q + {1'b0, step_q};
    assign acc_int  = acc_q[AW-1:FRAC_WIDTH];
    assign next_int = acc_next[AW-1:FRAC_WIDTH];

    // inflight_q marks that fifo_rd_data carries the beat for position src_x_q.
    assign keep     = inflight_q && (out_cnt_q < dst_w_q) &&
                      ({1'b0, src_x_q} == acc_int);
    assign keep_eol = ((out_cnt_q + CNT_ONE) == dst_w_q) ||
                      (next_int >= {1'b0, src_w_q});

    always_comb begin
        state_d     = state_q;
        src_w_d     = src_w_q;
        dst_w_d     = dst_w_q;
        step_d      = step_q;
        acc_d       = acc_q;
        src_x_d     = src_x_q;
        issued_d    = issued_q;
        out_cnt_d   = out_cnt_q;
        inflight_d  = fifo_rd_en;
        buf0_data_d = buf0_data_q;
        buf1_data_d = buf1_data_q;
        buf0_eol_d  = buf0_eol_q;
        buf1_eol_d  = buf1_eol_q;
        buf_occ_d   = occ_after_pop + {1'b0, keep};
        line_done   = 1'b0;

        if (fifo_rd_en) begin
            issued_d = issued_q + CNT_ONE;
        end

        // Returned beat: advance position, maybe keep it.
        if (inflight_q) begin
            src_x_d = src_x_q + CNT_ONE;
            if (keep) begin
                acc_d     = acc_next;
                out_cnt_d = out_cnt_q + CNT_ONE;
            end
        end

        // Skid buffer: shift on pop, then append behind whatever remains.
        if (pop) begin
            buf0_data_d = buf1_data_q;
            buf0_eol_d  = buf1_eol_q;
        end
        if (keep) begin
            if (occ_after_pop == 2'd0) begin
                buf0_data_d = fifo_rd_data;
                buf0_eol_d  = keep_eol;
            end else begin
                buf1_data_d = fifo_rd_data;
                buf1_eol_d  = keep_eol;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // src_x counts returned beats, so no read is in flight here.
                if (src_x_q == src_w_q) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (buf_occ_q == 2'd0) begin
                    state_d = S_END;
                end
            end
            S_END: begin
                line_done = 1'b1;
                state_d   = enable ? S_RUN : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Line start: latch configuration and clear the per-line counters.
        if ((state_q == S_IDLE || state_q == S_END) && enable) begin
            src_w_d   = src_width;
            dst_w_d   = dst_width;
            step_d    = step;
            // A ratio below 1.0 would keep one input pixel several times.
            if (step[SW-1:FRAC_WIDTH] == '0) begin
                step_d = SW'(1) << FRAC_WIDTH;
            end
            acc_d     = '0;
            src_x_d   = '0;
            issued_d  = '0;
            out_cnt_d = '0;
        end
    end

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            state_q     <= S_IDLE;
            src_w_q     <= '0;
            dst_w_q     <= '0;
            step_q      <= '0;
            acc_q       <= '0;
            src_x_q     <= '0;
            issued_q    <= '0;
            out_cnt_q   <= '0;
            inflight_q  <= 1'b0;   // drops any read in flight
            buf0_data_q <= '0;
            buf1_data_q <= '0;
            buf0_eol_q  <= 1'b0;
            buf1_eol_q  <= 1'b0;
            buf_occ_q   <= 2'd0;
        end else begin
            state_q     <= state_d;
            src_w_q     <= src_w_d;
            dst_w_q     <= dst_w_d;
            step_q      <= step_d;
            acc_q       <= acc_d;
            src_x_q     <= src_x_d;
            issued_q    <= issued_d;
            out_cnt_q   <= out_cnt_d;
            inflight_q  <= inflight_d;
            buf0_data_q <= buf0_data_d;
            buf1_data_q <= buf1_data_d;
            buf0_eol_q  <= buf0_eol_d;
            buf1_eol_q  <= buf1_eol_d;
            buf_occ_q   <= buf_occ_d;
        end
    end

endmodule

// File: tb/tb_scale_hdown_reader.sv
// ---------------------------------------------------------------------------
// tb_scale_hdown_reader
//
// Bench for scale_hdown_reader. A behavioural FIFO (1-cycle read latency)
// feeds the DUT; expected output pixels {eol, data} are pushed into exp_q as
// each line is issued, and a monitor pops and compares on every accepted
// output pixel.
// ---------------------------------------------------------------------------
module tb_scale_hdown_reader;

    localparam int DW = 16;
    localparam int CW = 12;
    localparam int FW = 8;

    // ---------------- clock / reset ----------------
    logic rd_clk = 1'b0;
    always #5 rd_clk = ~rd_clk;

    logic               rd_rst;
    logic               enable;
    logic [CW-1:0]      src_width;
    logic [CW-1:0]      dst_width;
    logic [CW+FW-1:0]   step;
    logic               fifo_rd_en;
    logic [DW-1:0]      fifo_rd_data;
    logic               fifo_empty;
    logic [DW-1:0]      pix_data;
    logic               pix_valid;
    logic               pix_ready;
    logic               pix_eol;
    logic               line_done;
    logic               busy;
    logic [1:0]         dbg_state;

    scale_hdown_reader #(
        .DATA_WIDTH(DW),
        .CNT_WIDTH (CW),
        .FRAC_WIDTH(FW)
    ) dut (
        .rd_clk      (rd_clk),
        .rd_rst      (rd_rst),
        .enable      (enable),
        .src_width   (src_width),
        .dst_width   (dst_width),
        .step        (step),
        .fifo_rd_en  (fifo_rd_en),
        .fifo_rd_data(fifo_rd_data),
        .fifo_empty  (fifo_empty),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_eol     (pix_eol),
        .line_done   (line_done),
        .busy        (busy),
        .dbg_state   (dbg_state)
    );

    // ---------------- shared state ----------------
    logic [DW:0]  exp_q[$];       // expected {eol, data}
    logic [DW-1:0] src_q[$];      // FIFO contents
    string        chk_name_q[$];  // scalar checks queued by the stimulus
    logic [31:0]  chk_act_q[$];
    logic [31:0]  chk_exp_q[$];
    int           acc_cyc_q[$];   // cycle index of each accepted pixel

    int n_checks = 0;
    int n_fail   = 0;
    int rd_cnt   = 0;
    int ld_cnt   = 0;
    int acc_cnt  = 0;
    int cyc      = 0;

    // ---------------- FIFO model ----------------
    always @(posedge rd_clk) begin
        if (fifo_rd_en) begin
            rd_cnt = rd_cnt + 1;
            if (src_q.size() > 0) begin
                fifo_rd_data <= src_q.pop_front();
            end
        end
    end

    always @(negedge rd_clk) begin
        fifo_empty = (src_q.size() == 0);
    end

    // ---------------- monitor / scoreboard ----------------
    string       m_name;
    logic [31:0] m_act;
    logic [31:0] m_exp;
    logic [DW:0] m_pix;

    always @(negedge rd_clk) begin
        cyc = cyc + 1;
        while (chk_name_q.size() > 0) begin
            m_name = chk_name_q.pop_front();
            m_act  = chk_act_q.pop_front();
            m_exp  = chk_exp_q.pop_front();
            n_checks = n_checks + 1;
            if (m_act !== m_exp) begin
                n_fail = n_fail + 1;
                $display("FAIL %s: got 0x%0h, expected 0x%0h", m_name, m_act, m_exp);
            end
        end
        if (line_done === 1'b1) begin
            ld_cnt = ld_cnt + 1;
        end
        if (rd_rst === 1'b0 && pix_valid === 1'b1) begin
            if (pix_ready === 1'b1) begin
                n_checks = n_checks + 1;
                if (exp_q.size() == 0) begin
                    n_fail = n_fail + 1;
                    $display("FAIL pix_unexpected: got eol=%0b data=0x%0h, expected no pixel",
                             pix_eol, pix_data);
                end else begin
                    m_pix = exp_q.pop_front();
                    if ({pix_eol, pix_data} !== m_pix) begin
                        n_fail = n_fail + 1;
                        $display("FAIL pix_out: got eol=%0b data=0x%0h, expected eol=%0b data=0x%0h",
                                 pix_eol, pix_data, m_pix[DW], m_pix[DW-1:0]);
                    end
                end
                acc_cnt = acc_cnt + 1;
                acc_cyc_q.push_back(cyc);
            end else if (exp_q.size() > 0) begin
                n_checks = n_checks + 1;
                if ({pix_eol, pix_data} !== exp_q[0]) begin
                    n_fail = n_fail + 1;
                    $display("FAIL pix_hold: got eol=%0b data=0x%0h, expected eol=%0b data=0x%0h",
                             pix_eol, pix_data, exp_q[0][DW], exp_q[0][DW-1:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n = 1);
        repeat (n) @(posedge rd_clk);
        #1;
    endtask

    task automatic req(input string nm, input logic [31:0] act, input logic [31:0] expv);
        chk_name_q.push_back(nm);
        chk_act_q.push_back(act);
        chk_exp_q.push_back(expv);
    endtask

    task automatic load_line(input int n, input logic [DW-1:0] base, input logic [DW-1:0] inc);
        logic [DW-1:0] v;
        for (int x = 0; x < n; x++) begin
            v = base + inc * DW'(x);
            src_q.push_back(v);
        end
    endtask

    task automatic expect_pix(input logic [DW-1:0] d, input logic e);
        exp_q.push_back({e, d});
    endtask

    task automatic set_cfg(input int src, input int dst, input int stp);
        src_width = CW'(src);
        dst_width = CW'(dst);
        step      = (CW+FW)'(stp);
    endtask

    // One line: enable is held for a single edge so exactly one line runs.
    task automatic start_line(input int src, input int dst, input int stp);
        set_cfg(src, dst, stp);
        enable = 1'b1;
        tick();
        enable = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int ld0;
        int n;
        ld0 = ld_cnt;
        n = 0;
        while (ld_cnt == ld0 && n < 400) begin
            tick();
            n++;
        end
        tick(2);
        req({nm, "_line_done"}, ld_cnt - ld0, 1);
    endtask

    task automatic wait_accepts(input int a0, input int target);
        int n;
        n = 0;
        while ((acc_cnt - a0) < target && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic end_checks(input string nm, input int rd0, input int a0,
                              input int exp_reads, input int exp_pix);
        tick(2);
        req({nm, "_reads"},     rd_cnt - rd0,  exp_reads);
        req({nm, "_pix_count"}, acc_cnt - a0,  exp_pix);
        req({nm, "_fifo_left"}, src_q.size(),  0);
        req({nm, "_exp_left"},  exp_q.size(),  0);
        req({nm, "_busy"},      busy,          0);
    endtask

    // ---------------- stimulus ----------------
    int rd0;
    int a0;
    int c0;
    int l0;
    int span;

    initial begin
        rd_rst    = 1'b1;
        enable    = 1'b0;
        pix_ready = 1'b1;
        set_cfg(0, 0, 0);
        tick(3);
        req("reset_outs", {fifo_rd_en, pix_valid, pix_eol, line_done, busy, dbg_state, pix_data}, 0);
        rd_rst = 1'b0;
        tick();

        // 1) 8 -> 4, step 2.0
        rd0 = rd_cnt; a0 = acc_cnt;
        load_line(8, 16'h0000, 16'h0010);
        expect_pix(16'h0000, 1'b0);
        expect_pix(16'h0020, 1'b0);
        expect_pix(16'h0040, 1'b0);
        expect_pix(16'h0060, 1'b1);
        start_line(8, 4, 'h200);
        wait_done("t1");
        end_checks("t1", rd0, a0, 8, 4);

        // 2) 6 -> 4, step 1.5: keep x = 0,1,3,4
        rd0 = rd_cnt; a0 = acc_cnt;
        load_line(6, 16'hA000, 16'h0001);
        expect_pix(16'hA000, 1'b0);
        expect_pix(16'hA001, 1'b0);
        expect_pix(16'hA003, 1'b0);
        expect_pix(16'hA004, 1'b1);
        start_line(6, 4, 'h180);
        wait_done("t2");
        end_checks("t2", rd0, a0, 6, 4);

        // 3) passthrough 5 -> 5, back-to-back output
        rd0 = rd_cnt; a0 = acc_cnt; c0 = acc_cyc_q.size();
        load_line(5, 16'h5500, 16'h0011);
        expect_pix(16'h5500, 1'b0);
        expect_pix(16'h5511, 1'b0);
        expect_pix(16'h5522, 1'b0);
        expect_pix(16'h5533, 1'b0);
        expect_pix(16'h5544, 1'b1);
        start_line(5, 5, 'h100);
        wait_done("t3");
        end_checks("t3", rd0, a0, 5, 5);
        span = (acc_cyc_q.size() >= c0 + 5) ? (acc_cyc_q[c0+4] - acc_cyc_q[c0]) : -1;
        req("t3_consecutive_span", span, 4);

        // 4) case 1 with a 10-cycle downstream stall mid-line
        rd0 = rd_cnt; a0 = acc_cnt;
        load_line(8, 16'h0000, 16'h0010);
        expect_pix(16'h0000, 1'b0);
        expect_pix(16'h0020, 1'b0);
        expect_pix(16'h0040, 1'b0);
        expect_pix(16'h0060, 1'b1);
        start_line(8, 4, 'h200);
        wait_accepts(a0, 2);
        pix_ready = 1'b0;
        tick(10);
        req("t4_rd_stalled", fifo_rd_en, 0);
        req("t4_valid_held", pix_valid, 1);
        pix_ready = 1'b1;
        wait_done("t4");
        end_checks("t4", rd0, a0, 8, 4);

        // 5a) upscale ratio clipped to source: 4 -> 8, step 1.0
        rd0 = rd_cnt; a0 = acc_cnt;
        load_line(4, 16'h0F00, 16'h0101);
        expect_pix(16'h0F00, 1'b0);
        expect_pix(16'h1001, 1'b0);
        expect_pix(16'h1102, 1'b0);
        expect_pix(16'h1203, 1'b1);
        start_line(4, 8, 'h100);
        wait_done("t5a");
        end_checks("t5a", rd0, a0, 4, 4);

        // 5b) dst = 0: line drained, nothing emitted
        rd0 = rd_cnt; a0 = acc_cnt;
        load_line(4, 16'hBE00, 16'h0001);
        start_line(4, 0, 'h100);
        wait_done("t5b");
        end_checks("t5b", rd0, a0, 4, 0);

        // 5c) src = 0: no reads at all
        rd0 = rd_cnt; a0 = acc_cnt;
        start_line(0, 4, 'h100);
        wait_done("t5c");
        end_checks("t5c", rd0, a0, 0, 0);

        // 6) reset at the 3rd output pixel, then enable drops mid-line
        a0 = acc_cnt;
        load_line(8, 16'h0000, 16'h0010);
        expect_pix(16'h0000, 1'b0);
        expect_pix(16'h0020, 1'b0);
        expect_pix(16'h0040, 1'b0);
        expect_pix(16'h0060, 1'b1);
        start_line(8, 4, 'h200);
        wait_accepts(a0, 2);
        rd_rst = 1'b1;
        tick();
        req("t6_reset_outs", {fifo_rd_en, pix_valid, pix_eol, line_done, busy, dbg_state, pix_data}, 0);
        tick();
        rd_rst = 1'b0;
        src_q.delete();
        exp_q.delete();
        tick();

        rd0 = rd_cnt; a0 = acc_cnt; l0 = ld_cnt;
        load_line(8, 16'h7000, 16'h0010);
        expect_pix(16'h7000, 1'b0);
        expect_pix(16'h7020, 1'b0);
        expect_pix(16'h7040, 1'b0);
        expect_pix(16'h7060, 1'b1);
        set_cfg(8, 4, 'h200);
        enable = 1'b1;
        tick(4);
        req("t6_busy_mid", busy, 1);
        enable = 1'b0;
        wait_done("t6");
        end_checks("t6", rd0, a0, 8, 4);
        tick(5);
        req("t6_state_idle", dbg_state, 0);
        req("t6_single_line", ld_cnt - l0, 1);

        tick(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
